// File: rtl/ext_pipe_pkg.sv
// Shared control defines for the immediate-extension pipeline.
// Extends the EXTOP code set used by the decode stages.
package ext_pipe_pkg;
  typedef logic [1:0] extop_t;

  localparam extop_t EXTOP_ZERO = 2'd0;
  localparam extop_t EXTOP_SIGN = 2'd1;
  localparam extop_t EXTOP_HIGH = 2'd2;
  localparam extop_t EXTOP_PAIR = 2'd3;
endpackage

// File: rtl/ext_pipe_if.sv
// Request/response bundle between an immediate producer and ext_pipe.
// master drives beats and consumes results; slave is the pipeline stage.
interface ext_pipe_if #(
  parameter int IMM_W = 16,
  parameter int OUT_W = 32
);
  import ext_pipe_pkg::*;

  logic             flush;
  logic             in_valid;
  logic             in_ready;
  extop_t           ext_op;
  logic [IMM_W-1:0] imm;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] imm_out;
  logic             pair_pending;

  modport master (
    output flush, in_valid, ext_op, imm, out_ready,
    input  in_ready, out_valid, imm_out, pair_pending
  );

  modport slave (
    input  flush, in_valid, ext_op, imm, out_ready,
    output in_ready, out_valid, imm_out, pair_pending
  );
endinterface

// File: rtl/ext_pipe_core.sv
// Combinational single-beat extender: ZERO, SIGN and HIGH modes.
// PAIR needs two beats and is assembled by the enclosing stage.
module ext_core
  import ext_pipe_pkg::*;
#(
  parameter int IMM_W = 16,
  parameter int OUT_W = 32
) (
  input  extop_t           op,
  input  logic [IMM_W-1:0] imm,
  output logic [OUT_W-1:0] res
);
  always_comb begin
    res = '0;
    case (op)
      EXTOP_ZERO: res[IMM_W-1:0] = imm;
      EXTOP_SIGN: res = {{(OUT_W-IMM_W){imm[IMM_W-1]}}, imm};
      EXTOP_HIGH: res[2*IMM_W-1:IMM_W] = imm;
      default:    res = '0;
    endcase
  end
endmodule

// File: rtl/ext_pipe.sv
// Registered immediate-extension stage with valid/ready handshake.
// Single-beat modes go through ext_core; PAIR joins two beats as {hi, lo}.
module ext_pipe
  import ext_pipe_pkg::*;
#(
  parameter int IMM_W = 16,
  parameter int OUT_W = 32
) (
  input  logic       clk,
  input  logic       rst,
  ext_pipe_if.slave  bus
);
  localparam logic [0:0] S_IDLE    = 1'b0;
  localparam logic [0:0] S_HI_HELD = 1'b1;

  if (OUT_W < 2*IMM_W) begin : g_bad_param
    $error("ext_pipe: OUT_W must be >= 2*IMM_W");
  end

  logic [0:0]       state;
  logic [IMM_W-1:0] hi;
  logic             out_valid;
  logic [OUT_W-1:0] imm_out;
  logic [OUT_W-1:0] core_res;
  logic [OUT_W-1:0] pair_res;
  logic             accept;
  logic             consume;

  ext_core #(.IMM_W(IMM_W), .OUT_W(OUT_W)) u_core (
    .op  (bus.ext_op),
    .imm (bus.imm),
    .res (core_res)
  );

  always_comb begin
    pair_res = '0;
    pair_res[2*IMM_W-1:0] = {hi, bus.imm};
  end

  assign bus.in_ready     = !out_valid || bus.out_ready;
  assign accept           = bus.in_valid && bus.in_ready && !bus.flush;
  assign consume          = out_valid && bus.out_ready;
  assign bus.out_valid    = out_valid;
  assign bus.imm_out      = imm_out;
  assign bus.pair_pending = (state == S_HI_HELD);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      hi        <= '0;
      out_valid <= 1'b0;
      imm_out   <= '0;
    end else if (bus.flush) begin
      // imm_out is left as-is; out_valid=0 already marks it stale
      state     <= S_IDLE;
      hi        <= '0;
      out_valid <= 1'b0;
    end else if (accept) begin
      if (state == S_HI_HELD) begin
        imm_out   <= pair_res;
        out_valid <= 1'b1;
        hi        <= '0;
        state     <= S_IDLE;
      end else if (bus.ext_op == EXTOP_PAIR) begin
        // first half only: nothing new to present, old result may drain
        hi    <= bus.imm;
        state <= S_HI_HELD;
        if (consume) out_valid <= 1'b0;
      end else begin
        imm_out   <= core_res;
        out_valid <= 1'b1;
      end
    end else if (consume) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_ext_pipe.sv
// Scoreboard bench for ext_pipe: default 16/32 instance plus an 8/24 instance.
// Expected results are queued at acceptance and popped by per-instance monitors.
module tb_ext_pipe;
  import ext_pipe_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ext_pipe_if #(.IMM_W(16), .OUT_W(32)) bus0 ();
  ext_pipe_if #(.IMM_W(8),  .OUT_W(24)) bus1 ();

  ext_pipe #(.IMM_W(16), .OUT_W(32)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
  ext_pipe #(.IMM_W(8),  .OUT_W(24)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int ncmp  = 0;
  int nfail = 0;
  logic [31:0] q0[$];
  logic [31:0] q1[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // present a beat on dut0, wait (bounded) for acceptance, queue expectation
  task automatic send0(input extop_t op, input logic [15:0] v, input bit push, input logic [31:0] e);
    int n = 0;
    bus0.in_valid = 1'b1; bus0.ext_op = op; bus0.imm = v;
    while (!bus0.in_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (n >= 50) begin
      ncmp++; nfail++;
      $display("FAIL send0_timeout: got in_ready=0 expected in_ready=1");
    end else if (push) q0.push_back(e);
    @(posedge clk); #1;
    bus0.in_valid = 1'b0;
  endtask

  task automatic send1(input extop_t op, input logic [7:0] v, input bit push, input logic [23:0] e);
    int n = 0;
    bus1.in_valid = 1'b1; bus1.ext_op = op; bus1.imm = v;
    while (!bus1.in_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (n >= 50) begin
      ncmp++; nfail++;
      $display("FAIL send1_timeout: got in_ready=0 expected in_ready=1");
    end else if (push) q1.push_back({8'h00, e});
    @(posedge clk); #1;
    bus1.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  always @(negedge clk) begin
    if (!rst && bus0.out_valid && bus0.out_ready) begin
      if (q0.size() == 0) chk("dut0_unexpected_out", bus0.imm_out, 32'hxxxxxxxx);
      else chk("dut0_out", bus0.imm_out, q0.pop_front());
    end
  end

  always @(negedge clk) begin
    if (!rst && bus1.out_valid && bus1.out_ready) begin
      if (q1.size() == 0) chk("dut1_unexpected_out", {8'h00, bus1.imm_out}, 32'hxxxxxxxx);
      else chk("dut1_out", {8'h00, bus1.imm_out}, q1.pop_front());
    end
  end

  initial begin
    bus0.flush = 1'b0; bus0.in_valid = 1'b0; bus0.ext_op = EXTOP_ZERO; bus0.imm = '0; bus0.out_ready = 1'b1;
    bus1.flush = 1'b0; bus1.in_valid = 1'b0; bus1.ext_op = EXTOP_ZERO; bus1.imm = '0; bus1.out_ready = 1'b1;
    idle(3);
    rst = 1'b0;
    chk("rst_out_valid",    {31'b0, bus0.out_valid},    32'd0);
    chk("rst_imm_out",      bus0.imm_out,               32'd0);
    chk("rst_pair_pending", {31'b0, bus0.pair_pending}, 32'd0);
    chk("rst_in_ready",     {31'b0, bus0.in_ready},     32'd1);

    // sign extension, negative and positive
    send0(EXTOP_SIGN, 16'h8001, 1'b1, 32'hFFFF8001);
    chk("sign_out_valid", {31'b0, bus0.out_valid}, 32'd1);
    send0(EXTOP_SIGN, 16'h7FFF, 1'b1, 32'h00007FFF);

    // PAIR back-to-back; second op code is ignored
    send0(EXTOP_PAIR, 16'h1234, 1'b0, 32'h0);
    chk("pair_pending_set", {31'b0, bus0.pair_pending}, 32'd1);
    chk("pair_no_out",      {31'b0, bus0.out_valid},    32'd0);
    send0(EXTOP_HIGH, 16'hABCD, 1'b1, 32'h1234ABCD);
    chk("pair_pending_clr", {31'b0, bus0.pair_pending}, 32'd0);
    idle(1);

    // backpressure: held result, new beat refused until out_ready returns
    bus0.out_ready = 1'b0;
    send0(EXTOP_HIGH, 16'h00FF, 1'b1, 32'h00FF0000);
    bus0.in_valid = 1'b1; bus0.ext_op = EXTOP_ZERO; bus0.imm = 16'hFFFF;
    repeat (3) begin
      @(negedge clk);
      chk("stall_in_ready", {31'b0, bus0.in_ready}, 32'd0);
      chk("stall_hold",     bus0.imm_out,           32'h00FF0000);
      @(posedge clk); #1;
    end
    bus0.out_ready = 1'b1;
    q0.push_back(32'h0000FFFF);
    @(posedge clk); #1;
    bus0.in_valid = 1'b0;
    idle(2);

    // streaming at full throughput
    for (int i = 1; i <= 3; i++) begin
      chk("stream_in_ready", {31'b0, bus0.in_ready}, 32'd1);
      send0(EXTOP_ZERO, 16'(i), 1'b1, 32'(i));
    end
    idle(2);

    // flush discards a held result
    bus0.out_ready = 1'b0;
    send0(EXTOP_ZERO, 16'h0042, 1'b0, 32'h0);
    bus0.flush = 1'b1;
    @(posedge clk); #1;
    bus0.flush = 1'b0;
    chk("flush_held_out_valid", {31'b0, bus0.out_valid}, 32'd0);
    bus0.out_ready = 1'b1;

    // flush mid-pair with a concurrent beat
    send0(EXTOP_PAIR, 16'h5555, 1'b0, 32'h0);
    bus0.flush = 1'b1; bus0.in_valid = 1'b1; bus0.ext_op = EXTOP_ZERO; bus0.imm = 16'h0099;
    @(posedge clk); #1;
    bus0.flush = 1'b0; bus0.in_valid = 1'b0;
    chk("flush_pair_out_valid", {31'b0, bus0.out_valid},    32'd0);
    chk("flush_pair_pending",   {31'b0, bus0.pair_pending}, 32'd0);
    send0(EXTOP_ZERO, 16'h0007, 1'b1, 32'h00000007);
    idle(1);

    // reset mid-pair discards the high half
    send0(EXTOP_PAIR, 16'h1111, 1'b0, 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_mid_pending",   {31'b0, bus0.pair_pending}, 32'd0);
    chk("rst_mid_imm_out",   bus0.imm_out,               32'd0);
    chk("rst_mid_out_valid", {31'b0, bus0.out_valid},    32'd0);
    send0(EXTOP_SIGN, 16'h8001, 1'b1, 32'hFFFF8001);

    // narrow instance
    send1(EXTOP_SIGN, 8'h80, 1'b1, 24'hFFFF80);
    send1(EXTOP_PAIR, 8'h12, 1'b0, 24'h0);
    send1(EXTOP_ZERO, 8'h34, 1'b1, 24'h001234);
    send1(EXTOP_HIGH, 8'hA5, 1'b1, 24'h00A500);

    idle(5);
    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
